// File: rtl/cpu_types_pkg.sv
// Shared types for the elastic pipeline stage: occupancy state encoding and
// the width of the optional performance counters.
package cpu_types_pkg;

  localparam int PERF_W = 32;

  // Encoding doubles as the occupancy count driven on occ.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/elastic_pipe_latch.sv
// Two-entry elastic pipeline stage (head + skid register) with flush/freeze.
// Define ELASTIC_PIPE_PERF_EN to build the stall/flush saturating counters.
module elastic_pipe_latch
  import cpu_types_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic              flush,
  input  logic              freeze,
  output logic [1:0]        occ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_accept;
  logic             w_consume;

  // in_ready depends only on held state and freeze, never on out_ready.
  assign in_ready  = (r_state != FULL)  && !freeze;
  assign out_valid = (r_state != EMPTY) && !freeze;
  assign out_data  = (r_state == EMPTY) ? BUBBLE : r_main;
  assign occ       = r_state;

  assign w_accept  = in_valid  && in_ready;
  assign w_consume = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = BUBBLE;
      w_skid_nxt  = BUBBLE;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ONE;
            w_main_nxt  = in_data;
          end
        end
        ONE: begin
          if (w_accept && w_consume) begin
            w_main_nxt = in_data;
          end else if (w_accept) begin
            w_state_nxt = FULL;
            w_skid_nxt  = in_data;
          end else if (w_consume) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          // Skid entry is younger, so it moves to head once head drains.
          if (w_consume) begin
            w_state_nxt = ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= EMPTY;
      r_main  <= BUBBLE;
      r_skid  <= BUBBLE;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

`ifdef ELASTIC_PIPE_PERF_EN
  sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
    .i_clk   (CLK),
    .i_inc   (in_valid && !in_ready),
    .i_clear (RST),
    .o_count (stall_cnt)
  );

  sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
    .i_clk   (CLK),
    .i_inc   (flush),
    .i_clear (RST),
    .o_count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_elastic_pipe_latch.sv
// Directed self-checking bench for elastic_pipe_latch (default and PERF_EN builds).
module tb_elastic_pipe_latch;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        flush;
  logic        freeze;
  logic [1:0]  occ;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  elastic_pipe_latch #(.WIDTH(32), .BUBBLE(32'h0)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .freeze    (freeze),
    .occ       (occ),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef ELASTIC_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; in_valid = 1'b0; flush = 1'b0; freeze = 1'b0; out_ready = 1'b0;
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF;
    out_ready = 1'b0; flush = 1'b0; freeze = 1'b0;
    tick();
    tick();
    RST = 1'b0; in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_tests++;
    if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data got %h want 00000000", out_data); end
    n_tests++;
    if (occ !== 2'd0) begin n_fail++; $display("FAIL rst_occ got %0d want 0", occ); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    n_tests++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_counters got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, in_ready); end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        n_fail++; $display("FAIL stream_out[%0d] got v=%0b d=%h want v=1 d=%h", i, out_valid, out_data, 32'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (occ !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_drain got occ=%0d v=%0b want occ=0 v=0", occ, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    n_tests++;
    if (occ !== 2'd2 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full got occ=%0d rdy=%0b want occ=2 rdy=0", occ, in_ready);
    end
    in_data = 32'hC; out_ready = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hA) begin
      n_fail++; $display("FAIL bp_first got v=%0b d=%h want v=1 d=0000000a", out_valid, out_data);
    end
    tick();
    n_tests++;
    if (out_data !== 32'hB || occ !== 2'd1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_second got d=%h occ=%0d rdy=%0b want d=0000000b occ=1 rdy=1", out_data, occ, in_ready);
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hC || occ !== 2'd1) begin
      n_fail++; $display("FAIL bp_third got v=%0b d=%h occ=%0d want v=1 d=0000000c occ=1", out_valid, out_data, occ);
    end
    tick();
    n_tests++;
    if (occ !== 2'd0) begin n_fail++; $display("FAIL bp_drain got occ=%0d want 0", occ); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    flush = 1'b1; in_data = 32'hC;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_tests++;
    if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      n_fail++; $display("FAIL flush_state got occ=%0d v=%0b d=%h want occ=0 v=0 d=00000000", occ, out_valid, out_data);
    end
    n_tests++;
    if (flush_cnt !== (PERF ? 32'd1 : 32'd0)) begin
      n_fail++; $display("FAIL flush_cnt got %0d want %0d", flush_cnt, PERF ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || out_data === 32'hC) begin
        n_fail++; $display("FAIL flush_dropped[%0d] got v=%0b d=%h want v=0", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_freeze();
    do_reset();
    in_valid = 1'b1; in_data = 32'h55; tick();
    in_data = 32'h66; out_ready = 1'b1; freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || occ !== 2'd1) begin
        n_fail++; $display("FAIL freeze_hold[%0d] got v=%0b rdy=%0b occ=%0d want v=0 rdy=0 occ=1", i, out_valid, in_ready, occ);
      end
      tick();
    end
    freeze = 1'b0; in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h55) begin
      n_fail++; $display("FAIL freeze_release got v=%0b d=%h want v=1 d=00000055", out_valid, out_data);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || occ !== 2'd0) begin
      n_fail++; $display("FAIL freeze_once got v=%0b occ=%0d want v=0 occ=0", out_valid, occ);
    end
  endtask

  task automatic test_stall_and_rst();
    do_reset();
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    in_data = 32'hC;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (stall_cnt !== (PERF ? 32'd5 : 32'd0)) begin
      n_fail++; $display("FAIL stall_cnt got %0d want %0d", stall_cnt, PERF ? 5 : 0);
    end
    n_tests++;
    if (occ !== 2'd2 || out_data !== 32'hA) begin
      n_fail++; $display("FAIL stall_hold got occ=%0d d=%h want occ=2 d=0000000a", occ, out_data);
    end
    RST = 1'b1; freeze = 1'b1; flush = 1'b0;
    tick();
    RST = 1'b0; freeze = 1'b0; in_valid = 1'b0;
    #1;
    n_tests++;
    if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'h0 || stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_override got occ=%0d v=%0b d=%h stall=%0d want 0/0/0/0", occ, out_valid, out_data, stall_cnt);
    end
  endtask

  initial begin
    RST = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; freeze = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_freeze();
    test_stall_and_rst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_latch.md
ELASTIC_PIPE_LATCH -- requirements
Module: elastic_pipe_latch

Interface
REQ-001 Parameter WIDTH, default 32, payload bits carried per transfer (1..512).
REQ-002 Parameter BUBBLE, default '0, payload value driven on out_data when the stage holds no valid entry.
REQ-003 CLK  input  1  clock; all state updates on posedge CLK.
REQ-004 RST  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 in_valid  input  1  upstream offers in_data this cycle.
REQ-006 in_ready  output  1  stage accepts in_data this cycle; registered, combinationally independent of out_ready.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 out_valid  output  1  out_data is a valid entry.
REQ-009 out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 out_data  output  WIDTH  head-entry payload.
REQ-011 flush  input  1  discard all held entries and any concurrent input.
REQ-012 freeze  input  1  hold all state; no transfer on either side.
REQ-013 occ  output  2  number of held entries (0..2).

Function
REQ-014 Storage SHALL be a main register (head) plus one skid register; state encoded EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
REQ-015 Accept = in_valid & in_ready & !freeze; consume = out_valid & out_ready & !freeze.
REQ-016 in_ready SHALL equal (state != FULL) & !freeze.
REQ-017 out_valid SHALL equal (state != EMPTY) & !freeze; out_data SHALL be main payload, or BUBBLE when EMPTY.
REQ-018 Latency SHALL be one cycle: data accepted at edge N appears on out_data after edge N+1's preceding edge, i.e. visible in cycle N+1.
REQ-019 Sustained throughput SHALL be one transfer per cycle while out_ready stays high.
REQ-020 EMPTY: accept -> ONE (main <= in_data).
REQ-021 ONE: accept & consume -> ONE (main <= in_data); accept only -> FULL (skid <= in_data); consume only -> EMPTY.
REQ-022 FULL: consume -> ONE (main <= skid); accept impossible since in_ready=0.
REQ-023 flush SHALL take priority over accept, consume and freeze: next state EMPTY, main and skid <= BUBBLE; an input offered in the flush cycle is dropped.
REQ-024 freeze without flush SHALL hold state and payload unchanged.
REQ-025 FIFO order SHALL be preserved; no entry duplicated or lost except by flush.

Reset
REQ-026 With RST high at a posedge: state EMPTY, main and skid <= BUBBLE, so out_valid=0, out_data=BUBBLE, in_ready=1 (unless freeze), occ=0, counters 0.
REQ-027 RST SHALL override flush, freeze and any transfer in progress, including mid-FULL.

Configuration
REQ-028 Macro ELASTIC_PIPE_PERF_EN defined: outputs stall_cnt (32) counting cycles with in_valid & !in_ready, and flush_cnt (32) counting flush cycles; both saturate at all-ones, clear on RST.
REQ-029 Macro undefined: stall_cnt and flush_cnt ports still exist and are tied to 0; no counter logic synthesised.

Structure
REQ-030 Shared package (cpu_types_pkg) SHALL hold the state enum (EMPTY, ONE, FULL) and a perf-counter width constant of 32.
REQ-031 Counters SHALL be a sub-module sat_counter (WIDTH parameter, inc, clear), instantiated twice only under ELASTIC_PIPE_PERF_EN.
REQ-032 The block SHALL be usable as a drop-in decode/execute or execute/memory stage by packing a control/data struct into in_data.

Verification
REQ-033 Reset: RST high 2 cycles with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, out_data=0, occ=0, in_ready=1 after release.
REQ-034 Streaming: out_ready=1, push 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive cycles, each one cycle after acceptance, in_ready never low.
REQ-035 Backpressure: push 0xA, 0xB with out_ready=0 -> occ=2, in_ready=0; raise out_ready -> 0xA then 0xB delivered, 0xC offered meanwhile accepted after 0xB-position frees, order A,B,C.
REQ-036 Flush while FULL with concurrent in_valid (0xC) -> next cycle occ=0, out_valid=0, out_data=BUBBLE, 0xC never appears; flush_cnt=1 when PERF_EN.
REQ-037 Freeze in ONE with out_ready=1 for 3 cycles -> out_valid=0, in_ready=0, occ=1 held; release -> held payload delivered once.
REQ-038 PERF_EN: hold FULL with in_valid=1 for 5 cycles -> stall_cnt=5; without macro stall_cnt stays 0.
